// File: rtl/lsu_pkg.sv
// Shared types and widths for the load/store unit.
package lsu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DST_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_timeout_cnt.sv
// Wait counter for an outstanding memory access; tc flags the last allowed REQ cycle.
module lsu_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

    logic [7:0] cnt_r;

    // Count REQ cycles without ack; clear takes priority over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (clr) begin
            cnt_r <= 8'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    assign tc = (cnt_r == TC_VAL);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the EX/MEM register and data memory.
// Optional misaligned-address rejection is enabled by defining LSU_ALIGN_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [DST_W-1:0]  ex_dst,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [DST_W-1:0]  wb_dst,
    output logic              err
);

    lsu_state_e        state_r, state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              we_r;
    logic [DST_W-1:0]  dst_r;
    logic              wb_valid_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [DST_W-1:0]  wb_dst_r;
    logic              err_r;

    logic in_req_s, misalign_s, accept_s, illegal_s, ack_s, timeout_s, tc_s, stall_s;

    // Request decode, next-state selection and the combinational stall
    always_comb begin
        in_req_s    = (state_r == ST_REQ);
`ifdef LSU_ALIGN_CHECK_EN
        misalign_s  = ex_addr[0] & (ex_mem_read | ex_mem_write);
`else
        misalign_s  = 1'b0;
`endif
        accept_s    = ~in_req_s & ex_valid & (ex_mem_read ^ ex_mem_write) & ~misalign_s;
        illegal_s   = ~in_req_s & ex_valid & ((ex_mem_read & ex_mem_write) | misalign_s);
        ack_s       = in_req_s & mem_ack;
        timeout_s   = in_req_s & ~mem_ack & tc_s;
        stall_s     = rst_n & (in_req_s | accept_s);
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_nxt_s = ST_RESP;
                end else if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, latched request fields (zeroed outside REQ) and writeback/err pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            we_r       <= 1'b0;
            dst_r      <= {DST_W{1'b0}};
            wb_valid_r <= 1'b0;
            wb_data_r  <= {DATA_W{1'b0}};
            wb_dst_r   <= {DST_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wb_valid_r <= ack_s & ~we_r;
            err_r      <= illegal_s | timeout_s;
            if (accept_s) begin
                addr_r  <= ex_addr;
                wdata_r <= ex_wdata;
                we_r    <= ex_mem_write;
                dst_r   <= ex_dst;
            end else if (ack_s | timeout_s) begin
                addr_r  <= {ADDR_W{1'b0}};
                wdata_r <= {DATA_W{1'b0}};
                we_r    <= 1'b0;
            end
            if (ack_s & ~we_r) begin
                wb_data_r <= mem_rdata;
                wb_dst_r  <= dst_r;
            end
        end
    end

    lsu_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_s | ack_s | timeout_s),
        .en    (in_req_s & ~mem_ack),
        .tc    (tc_s)
    );

    assign stall     = stall_s;
    assign mem_req   = in_req_s;
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign wb_valid  = wb_valid_r;
    assign wb_data   = wb_data_r;
    assign wb_dst    = wb_dst_r;
    assign err       = err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level model plus directed scenarios.
module tb_load_store_unit;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [15:0] ex_addr = 16'h0000, ex_wdata = 16'h0000;
    logic [2:0]  ex_dst = 3'd0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'hDEAD;
    logic        stall, mem_req, mem_we, wb_valid, err;
    logic [15:0] mem_addr, mem_wdata, wb_data;
    logic [2:0]  wb_dst;

    int total = 0;
    int bad = 0;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_dst(ex_dst),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_dst(wb_dst), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding access, counted in cycles waited
    logic        m_busy = 1'b0, m_we = 1'b0, m_wbv = 1'b0, m_err = 1'b0;
    logic [15:0] m_addr = 16'h0000, m_wdata = 16'h0000, m_wbd = 16'h0000;
    logic [2:0]  m_dst = 3'd0, m_wbdst = 3'd0;
    int          m_wait = 0;

    function automatic logic misaligned();
`ifdef LSU_ALIGN_CHECK_EN
        return ex_valid && (ex_mem_read || ex_mem_write) && ex_addr[0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic accept_now();
        return !m_busy && ex_valid && (ex_mem_read != ex_mem_write) && !misaligned();
    endfunction

    function automatic logic illegal_now();
        return !m_busy && ex_valid && ((ex_mem_read && ex_mem_write) || misaligned());
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_we <= 1'b0; m_wbv <= 1'b0; m_err <= 1'b0;
            m_addr <= 16'h0000; m_wdata <= 16'h0000; m_wbd <= 16'h0000;
            m_dst <= 3'd0; m_wbdst <= 3'd0; m_wait <= 0;
        end else if (m_busy) begin
            m_err <= 1'b0;
            if (mem_ack) begin
                m_busy <= 1'b0;
                m_wbv  <= !m_we;
                if (!m_we) begin
                    m_wbd   <= mem_rdata;
                    m_wbdst <= m_dst;
                end
            end else if (m_wait + 1 >= TIMEOUT) begin
                m_busy <= 1'b0;
                m_err  <= 1'b1;
                m_wbv  <= 1'b0;
            end else begin
                m_wait <= m_wait + 1;
                m_wbv  <= 1'b0;
            end
        end else begin
            m_wbv <= 1'b0;
            m_err <= illegal_now();
            if (accept_now()) begin
                m_busy <= 1'b1; m_wait <= 0;
                m_addr <= ex_addr; m_wdata <= ex_wdata;
                m_we <= ex_mem_write; m_dst <= ex_dst;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        chk("stall", {15'd0, stall}, {15'd0, rst_n && (m_busy || accept_now())});
        chk("mem_req", {15'd0, mem_req}, {15'd0, m_busy});
        chk("mem_we", {15'd0, mem_we}, {15'd0, m_busy && m_we});
        chk("mem_addr", mem_addr, m_busy ? m_addr : 16'h0000);
        chk("mem_wdata", mem_wdata, m_busy ? m_wdata : 16'h0000);
        chk("wb_valid", {15'd0, wb_valid}, {15'd0, m_wbv});
        chk("err", {15'd0, err}, {15'd0, m_err});
        if (m_wbv) begin
            chk("wb_data", wb_data, m_wbd);
            chk("wb_dst", {13'd0, wb_dst}, {13'd0, m_wbdst});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        mem_ack = 1'b0; mem_rdata = 16'hDEAD;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic [2:0] dst);
        ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
        ex_addr = a; ex_wdata = d; ex_dst = dst;
    endtask

    int n_req, n_err;

    initial begin
        // reset state
        tick();
        @(negedge clk);
        chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
        chk("rst_wb_data", wb_data, 16'h0000);
        tick();
        rst_n = 1'b1;

        // load, ack in first REQ cycle
        issue(1'b1, 1'b0, 16'h0010, 16'h0000, 3'd5);
        @(negedge clk);
        chk("ld_stall_accept", {15'd0, stall}, 16'd1);
        tick();
        idle_in(); mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        @(negedge clk);
        chk("ld_addr", mem_addr, 16'h0010);
        chk("ld_stall_req", {15'd0, stall}, 16'd1);
        tick();
        idle_in();
        @(negedge clk);
        chk("ld_wb_valid", {15'd0, wb_valid}, 16'd1);
        chk("ld_wb_data", wb_data, 16'hBEEF);
        chk("ld_wb_dst", {13'd0, wb_dst}, 16'd5);
        chk("ld_stall_resp", {15'd0, stall}, 16'd0);
        tick();

        // store with ack delayed three cycles
        issue(1'b0, 1'b1, 16'h0020, 16'h1234, 3'd2);
        tick();
        idle_in();
        n_req = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            @(negedge clk);
            if (mem_req && mem_we && mem_addr == 16'h0020 && mem_wdata == 16'h1234) n_req++;
            tick();
        end
        idle_in();
        @(negedge clk);
        chk("st_req_cycles", 16'(n_req), 16'd4);
        chk("st_no_wb", {15'd0, wb_valid}, 16'd0);
        chk("st_stall_resp", {15'd0, stall}, 16'd0);
        tick();

        // back-to-back load then store with no idle bubble
        issue(1'b1, 1'b0, 16'h0030, 16'h0000, 3'd3);
        tick();
        idle_in(); mem_ack = 1'b1; mem_rdata = 16'h0A0A;
        tick();
        idle_in();
        issue(1'b0, 1'b1, 16'h0040, 16'h5555, 3'd0);
        @(negedge clk);
        chk("b2b_wb_data", wb_data, 16'h0A0A);
        tick();
        idle_in(); mem_ack = 1'b1;
        @(negedge clk);
        chk("b2b_req", {15'd0, mem_req}, 16'd1);
        chk("b2b_addr", mem_addr, 16'h0040);
        tick();
        idle_in();
        tick();

        // timeout with no ack
        issue(1'b1, 1'b0, 16'h0050, 16'h0000, 3'd1);
        tick();
        idle_in();
        n_req = 0; n_err = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) n_req++;
            if (err) n_err++;
            tick();
        end
        chk("to_req_cycles", 16'(n_req), 16'd15);
        chk("to_err_pulses", 16'(n_err), 16'd1);

        // stray ack and no-op request in IDLE
        ex_valid = 1'b1; mem_ack = 1'b1;
        tick();
        idle_in();
        @(negedge clk);
        chk("stray_ack_req", {15'd0, mem_req}, 16'd0);
        tick();

        // asynchronous reset in the second REQ cycle
        issue(1'b1, 1'b0, 16'h0060, 16'h0000, 3'd7);
        tick();
        idle_in();
        tick();
        chk("mid_req_before", {15'd0, mem_req}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {15'd0, mem_req}, 16'd0);
        chk("mid_rst_stall", {15'd0, stall}, 16'd0);
        tick();
        rst_n = 1'b1;
        issue(1'b1, 1'b0, 16'h0062, 16'h0000, 3'd6);
        tick();
        idle_in(); mem_ack = 1'b1; mem_rdata = 16'h7777;
        tick();
        idle_in();
        @(negedge clk);
        chk("post_rst_wb_data", wb_data, 16'h7777);
        chk("post_rst_wb_dst", {13'd0, wb_dst}, 16'd6);
        tick();

        // read and write both set
        issue(1'b1, 1'b1, 16'h0070, 16'h0000, 3'd0);
        tick();
        idle_in();
        @(negedge clk);
        chk("both_err", {15'd0, err}, 16'd1);
        chk("both_no_req", {15'd0, mem_req}, 16'd0);
        tick();

        // odd address
        issue(1'b1, 1'b0, 16'h0011, 16'h0000, 3'd4);
`ifdef LSU_ALIGN_CHECK_EN
        @(negedge clk);
        chk("align_no_stall", {15'd0, stall}, 16'd0);
        tick();
        idle_in();
        @(negedge clk);
        chk("align_err", {15'd0, err}, 16'd1);
        chk("align_no_req", {15'd0, mem_req}, 16'd0);
        tick();
`else
        tick();
        idle_in(); mem_ack = 1'b1; mem_rdata = 16'h0123;
        @(negedge clk);
        chk("odd_addr_pass", mem_addr, 16'h0011);
        tick();
        idle_in();
        tick();
`endif
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
